// File: rtl/modbus_rx_frame_ctrl.sv
// Modbus RTU receive frame controller: silence-delimited framing, buffer writes, CRC sequencing, status.
// Optional MODBUS_ADDR_FILTER_EN: frames for other stations complete without frame_done or status update.
module modbus_rx_frame_ctrl #(
  parameter int          T15_CYCLES  = 860,
  parameter int          T35_CYCLES  = 2006,
  parameter int          MAX_LEN     = 256,
  parameter logic [15:0] CRC_RESIDUE = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_err,
  input  logic [7:0]  my_addr,
  output logic [7:0]  crc_data,
  output logic        crc_en,
  output logic        crc_rst,
  input  logic [15:0] crc_value,
  output logic        buf_we,
  output logic [7:0]  buf_addr,
  output logic [7:0]  buf_wdata,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [8:0]  frame_len,
  output logic [2:0]  err_code,
  output logic        addr_match,
  output logic        busy
);

  localparam int            CW    = $clog2(T35_CYCLES + 1);
  localparam logic [CW-1:0] T15_C = CW'(T15_CYCLES);
  localparam logic [CW-1:0] T35_C = CW'(T35_CYCLES);
  localparam logic [8:0]    MAX_C = 9'(MAX_LEN);
  localparam logic [8:0]    OVF_C = 9'(MAX_LEN + 1);

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_RECV,
    ST_GAP,
    ST_CHECK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [8:0]    len_q, len_d;
  logic          am_q, am_d;
  logic          rxerr_q, rxerr_d;
  logic          gap_q, gap_d;
  logic [2:0]    err_d;
  logic          report;

  logic          frame_done_q, frame_ok_q, addr_match_q;
  logic [8:0]    frame_len_q;
  logic [2:0]    err_code_q;

  // NOTE: state uses non-blocking assignments in an async-reset always_ff so every
  // register samples the same pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (rx_valid) begin
      cnt_q <= '0;
    end else if (cnt_q != T35_C) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STARTUP;
      len_q   <= '0;
      am_q    <= 1'b0;
      rxerr_q <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      am_q    <= am_d;
      rxerr_q <= rxerr_d;
      gap_q   <= gap_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    am_d    = am_q;
    rxerr_d = rxerr_q;
    gap_d   = gap_q;
    crc_en  = 1'b0;
    crc_rst = 1'b0;
    buf_we  = 1'b0;
    buf_addr = '0;
    unique case (state_q)
      ST_STARTUP: begin
        crc_rst = 1'b1;
        if (!rx_valid && cnt_q == T35_C) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        crc_rst = !rx_valid;
        if (rx_valid) begin
          crc_en  = 1'b1;
          buf_we  = 1'b1;
          len_d   = 9'd1;
          am_d    = (rx_data == my_addr) || (rx_data == 8'h00);
          rxerr_d = rx_err;
          gap_d   = 1'b0;
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (rx_valid) begin
          crc_en = 1'b1;
          if (len_q < MAX_C) begin
            buf_we   = 1'b1;
            buf_addr = len_q[7:0];
          end
          if (len_q != OVF_C) len_d = len_q + 9'd1;
          if (rx_err) rxerr_d = 1'b1;
        end else if (cnt_q >= T15_C) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        // A late byte is only evidence of a broken frame; it never reaches CRC or buffer.
        if (rx_valid) gap_d = 1'b1;
        else if (cnt_q == T35_C) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        crc_rst = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_STARTUP;
    endcase
  end

  always_comb begin
    if (rxerr_q)                       err_d = 3'd5;
    else if (gap_q)                    err_d = 3'd4;
    else if (len_q > MAX_C)            err_d = 3'd3;
    else if (len_q < 9'd4)             err_d = 3'd2;
    else if (crc_value != CRC_RESIDUE) err_d = 3'd1;
    else                               err_d = 3'd0;
  end

`ifdef MODBUS_ADDR_FILTER_EN
  assign report = (state_q == ST_CHECK) && am_q;
`else
  assign report = (state_q == ST_CHECK);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_len_q  <= '0;
      err_code_q   <= '0;
      addr_match_q <= 1'b0;
    end else begin
      frame_done_q <= report;
      if (report) begin
        frame_ok_q   <= (err_d == 3'd0);
        frame_len_q  <= len_q;
        err_code_q   <= err_d;
        addr_match_q <= am_q;
      end
    end
  end

  assign crc_data   = rx_data;
  assign buf_wdata  = rx_data;
  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign frame_len  = frame_len_q;
  assign err_code   = err_code_q;
  assign addr_match = addr_match_q;
  assign busy       = (state_q == ST_RECV) || (state_q == ST_GAP) || (state_q == ST_CHECK);

endmodule

// File: tb/tb_modbus_rx_frame_ctrl.sv
// Self-checking bench for modbus_rx_frame_ctrl: directed and random frames against a frame-level model.
module tb_modbus_rx_frame_ctrl;

  localparam int T15     = 860;
  localparam int T35     = 2006;
  localparam int MAXL    = 256;
  localparam int WAIT_END = T35 + 40;

  logic        clk, rst;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_err;
  logic [7:0]  my_addr;
  logic [7:0]  crc_data;
  logic        crc_en, crc_rst;
  logic [15:0] crc_value;
  logic        buf_we;
  logic [7:0]  buf_addr, buf_wdata;
  logic        frame_done, frame_ok;
  logic [8:0]  frame_len;
  logic [2:0]  err_code;
  logic        addr_match, busy;

  int checks = 0;
  int errors = 0;

  modbus_rx_frame_ctrl #(
    .T15_CYCLES (T15),
    .T35_CYCLES (T35),
    .MAX_LEN    (MAXL),
    .CRC_RESIDUE(16'h0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .my_addr   (my_addr),
    .crc_data  (crc_data),
    .crc_en    (crc_en),
    .crc_rst   (crc_rst),
    .crc_value (crc_value),
    .buf_we    (buf_we),
    .buf_addr  (buf_addr),
    .buf_wdata (buf_wdata),
    .frame_done(frame_done),
    .frame_ok  (frame_ok),
    .frame_len (frame_len),
    .err_code  (err_code),
    .addr_match(addr_match),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  // External CRC-16 engine: synchronous reset to FFFF, one byte per enable, 1-cycle latency.
  logic [15:0] eng_q;
  logic        crc_override;
  always @(posedge clk) begin
    if (crc_rst)     eng_q <= 16'hFFFF;
    else if (crc_en) eng_q <= crc_upd(eng_q, crc_data);
  end
  assign crc_value = crc_override ? 16'h1234 : eng_q;

  int         crc_en_cnt, done_cnt;
  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  always @(negedge clk) begin
    if (crc_en) crc_en_cnt++;
    if (frame_done) done_cnt++;
    if (buf_we) begin
      wr_addr_q.push_back(buf_addr);
      wr_data_q.push_back(buf_wdata);
    end
  end

  logic [7:0] frame_q[$];
  logic       prev_ok, prev_am;
  logic [8:0] prev_len;
  logic [2:0] prev_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    rx_data  = b;
    rx_err   = e;
    rx_valid = 1'b1;
    step(1);
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    step(1);
  endtask

  task automatic build_frame(input logic [7:0] addr, input int nbody, input bit good_crc);
    logic [15:0] c;
    frame_q.delete();
    frame_q.push_back(addr);
    for (int i = 0; i < nbody; i++) frame_q.push_back(8'($urandom));
    if (good_crc) begin
      c = 16'hFFFF;
      foreach (frame_q[i]) c = crc_upd(c, frame_q[i]);
      frame_q.push_back(c[7:0]);
      frame_q.push_back(c[15:8]);
    end
  endtask

  task automatic clear_monitors();
    crc_en_cnt = 0;
    done_cnt   = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic run_frame(input string tag, input int gap_at, input int err_at);
    int          n, acc, exp_len, exp_err, nwr;
    logic [15:0] c;
    bit          exp_am, exp_done, wr_ok;
    n = frame_q.size();
    clear_monitors();
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) step(T15 + 10);
      send_byte(frame_q[i], i == err_at);
      if (i == 0) check({tag, " busy_in_frame"}, busy, 1);
    end
    step(WAIT_END);

    // Frame-level expectation derived from the byte list.
    acc     = (gap_at >= 0 && gap_at < n) ? gap_at : n;
    exp_len = (acc > MAXL + 1) ? MAXL + 1 : acc;
    nwr     = (acc > MAXL) ? MAXL : acc;
    c = 16'hFFFF;
    for (int i = 0; i < acc; i++) c = crc_upd(c, frame_q[i]);
    if (err_at >= 0 && err_at < acc)   exp_err = 5;
    else if (acc < n)                  exp_err = 4;
    else if (acc > MAXL)               exp_err = 3;
    else if (acc < 4)                  exp_err = 2;
    else if (crc_override || c != 0)   exp_err = 1;
    else                               exp_err = 0;
    exp_am = (frame_q[0] == my_addr) || (frame_q[0] == 8'h00);
`ifdef MODBUS_ADDR_FILTER_EN
    exp_done = exp_am;
`else
    exp_done = 1'b1;
`endif
    if (exp_done) begin
      prev_ok  = (exp_err == 0);
      prev_len = 9'(exp_len);
      prev_err = 3'(exp_err);
      prev_am  = exp_am;
    end

    check({tag, " done_pulses"}, done_cnt, exp_done ? 1 : 0);
    check({tag, " frame_ok"},    frame_ok,   prev_ok);
    check({tag, " frame_len"},   frame_len,  prev_len);
    check({tag, " err_code"},    err_code,   prev_err);
    check({tag, " addr_match"},  addr_match, prev_am);
    check({tag, " crc_en_cnt"},  crc_en_cnt, acc);
    check({tag, " buf_writes"},  wr_addr_q.size(), nwr);
    wr_ok = (wr_addr_q.size() == nwr);
    for (int i = 0; i < wr_addr_q.size() && i < nwr; i++)
      if (wr_addr_q[i] != 8'(i) || wr_data_q[i] != frame_q[i]) wr_ok = 1'b0;
    check({tag, " buf_contents"}, wr_ok, 1);
    check({tag, " busy_after"},   busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    rx_err = 1'b0;
    my_addr = 8'h22;
    crc_override = 1'b0;
    prev_ok = 1'b0;
    prev_am = 1'b0;
    prev_len = '0;
    prev_err = '0;
    clear_monitors();
    step(3);

    check("reset crc_rst",    crc_rst, 1);
    check("reset crc_en",     crc_en, 0);
    check("reset buf_we",     buf_we, 0);
    check("reset frame_done", frame_done, 0);
    check("reset status",     {frame_ok, frame_len, err_code, addr_match}, 0);
    check("reset busy",       busy, 0);

    // Bytes during startup silence are ignored.
    rst = 1'b0;
    step(2);
    clear_monitors();
    for (int i = 0; i < 3; i++) send_byte(8'(8'h22 + i), 1'b0);
    check("startup busy", busy, 0);
    step(WAIT_END);
    check("startup crc_en_cnt", crc_en_cnt, 0);
    check("startup done_cnt",   done_cnt, 0);

    build_frame(8'h22, 5, 1'b1);
    run_frame("good8", -1, -1);

    crc_override = 1'b1;
    run_frame("badcrc", -1, -1);
    crc_override = 1'b0;

    build_frame(8'h22, 2, 1'b0);
    run_frame("short3", -1, -1);

    build_frame(8'h22, 299, 1'b0);
    run_frame("ovf300", -1, -1);
    check("ovf300 last_wr_addr", wr_addr_q.size() > 0 ? wr_addr_q[$] : 8'h00, 8'd255);

    build_frame(8'h22, 5, 1'b1);
    run_frame("gap", 6, -1);

    build_frame(8'h22, 5, 1'b1);
    run_frame("rxerr", -1, 2);

    build_frame(8'h11, 5, 1'b1);
    run_frame("other_addr", -1, -1);

    build_frame(8'h00, 5, 1'b1);
    run_frame("broadcast", -1, -1);

    for (int r = 0; r < 6; r++) begin
      logic [7:0] a;
      int         sel;
      sel = $urandom_range(0, 2);
      a = (sel == 0) ? my_addr : (sel == 1) ? 8'h00 : 8'($urandom_range(1, 255));
      build_frame(a, $urandom_range(1, 12), $urandom_range(0, 3) != 0);
      run_frame($sformatf("rand%0d", r), -1,
                ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : -1);
    end

    // Reset mid-frame discards the frame and restarts the startup silence.
    clear_monitors();
    for (int i = 0; i < 3; i++) send_byte(8'(8'h22 + i), 1'b0);
    rst = 1'b1;
    step(2);
    check("midreset busy",    busy, 0);
    check("midreset crc_rst", crc_rst, 1);
    rst = 1'b0;
    prev_ok = 1'b0; prev_am = 1'b0; prev_len = '0; prev_err = '0;
    step(WAIT_END);
    check("midreset done_cnt", done_cnt, 0);
    check("midreset status",   {frame_ok, frame_len, err_code, addr_match}, 0);

    build_frame(8'h22, 3, 1'b1);
    run_frame("after_reset", -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/modbus_rx_frame_ctrl.md
Name: modbus_rx_frame_ctrl

Overview:
Modbus RTU receive-side frame controller. Consumes bytes from the UART receiver, delimits frames by inter-character silence (t1.5/t3.5), writes payload into an external frame buffer and sequences an external CRC-16 engine (init 16'hFFFF, synchronous reset, byte-wide enable) over every frame byte. At end of frame it checks the CRC residue, length and address, then reports one frame_done pulse with status to the protocol layer.

Parameters:
T15_CYCLES, 860, clk cycles of silence marking t1.5 (intra-frame gap violation)
T35_CYCLES, 2006, clk cycles of silence marking t3.5 (end of frame)
MAX_LEN, 256, maximum frame length in bytes including address and CRC
CRC_RESIDUE, 16'h0000, crc_value required after all frame bytes, CRC bytes included

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
rx_err  in  1  parity/framing error, qualified by rx_valid
my_addr  in  8  station address
crc_data  out  8  byte to CRC engine (equals rx_data)
crc_en  out  1  CRC engine enable
crc_rst  out  1  CRC engine synchronous reset (loads 16'hFFFF)
crc_value  in  16  CRC engine register output
buf_we  out  1  frame buffer write strobe
buf_addr  out  8  frame buffer write address
buf_wdata  out  8  frame buffer write data
frame_done  out  1  one-cycle pulse, frame ended, status valid
frame_ok  out  1  frame passed all checks
frame_len  out  9  bytes received, saturating at MAX_LEN+1
err_code  out  3  0 none, 1 crc, 2 short, 3 overflow, 4 gap, 5 rx_err
addr_match  out  1  byte 0 equals my_addr or 8'h00
busy  out  1  high in RECV, GAP, CHECK

Behaviour:
- Reset: state STARTUP; all outputs 0 except crc_rst=1; silence counter 0.
- Silence counter: cleared on rx_valid, else increments, saturating at T35_CYCLES.
- STARTUP: ignore bytes (counter still clears); counter reaches T35_CYCLES -> IDLE.
- IDLE: crc_rst=1 while rx_valid=0. rx_valid -> crc_rst=0, crc_en=1, buf_we=1, buf_addr=0, len=1, addr_match latched from rx_data, rx_err latched; -> RECV.
- RECV: each rx_valid -> crc_en=1; buf_we=1 at buf_addr=len while len<MAX_LEN; len increments, saturating at MAX_LEN+1. Counter reaches T15_CYCLES -> GAP.
- GAP: rx_valid -> latch gap error, byte dropped (no crc_en, no buf_we), remain GAP. Counter reaches T35_CYCLES -> CHECK.
- CHECK: one cycle (crc_value already reflects last byte; engine latency 1 cycle). Priority: rx_err > gap > overflow (len>MAX_LEN) > short (len<4) > crc (crc_value!=CRC_RESIDUE). frame_done=1, frame_ok=(err_code==0), frame_len, err_code, addr_match registered same cycle; -> IDLE.
- Status outputs hold until next frame_done; frame_done is exactly one cycle.
- crc_data = rx_data combinationally; crc_en and buf_we combinational from state and rx_valid.
- rx_valid coincident with counter reaching threshold: the byte wins (counter clears, no transition).
- Reset mid-frame: frame discarded, no frame_done, STARTUP re-entered.

Optional Feature:
MODBUS_ADDR_FILTER_EN: when defined, frames with addr_match=0 complete silently: no frame_done, status outputs unchanged, buffer writes still occur. When undefined, every frame raises frame_done and addr_match is informational.

Test Plan:
- Reset, no bytes for T35_CYCLES, then 8 bytes 1 cycle apart, crc_value=16'h0000 at CHECK -> frame_done after T35_CYCLES silence, frame_ok=1, frame_len=8, err_code=0, 8 crc_en pulses, buf_addr 0..7.
- Same frame, bench returns crc_value=16'h1234 -> frame_ok=0, err_code=1.
- 3-byte frame -> err_code=2, frame_len=3; 300-byte frame -> err_code=3, frame_len=257, last buf_we at buf_addr 255.
- Byte after T15_CYCLES+10 silence but before T35_CYCLES -> byte not fed to CRC, err_code=4 at frame end.
- Bytes arriving before startup silence expires -> no crc_en, no frame_done; rx_err on byte 2 -> err_code=5.
- Byte 0=8'h11, my_addr=8'h22: undefined macro -> frame_done=1, addr_match=0; defined -> no frame_done; byte 0=8'h00 -> addr_match=1 in both.
